effect_player: RTL and testbench
================================

# effect_player

Opcode consumer and executor for the decoration controller. It accepts 4-bit opcodes from the opcode sequencer over a valid/ready handshake and decodes each one into a timed actuator action: light, sound or motor. Each action holds its actuator for a programmed duration. The block returns to ready only when the action finishes, so the sequencer can stream a 4-entry program through it back-to-back.

## Interface
- TICK_CYCLES, 4, clk cycles per duration unit; legal range 1..64
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- op_valid  input  1  sequencer presents an opcode
- op_code  input  4  [3:2] effect select (0 nop, 1 light, 2 sound, 3 motor); [1:0] duration code d
- op_ready  output  1  block can accept an opcode this cycle
- abort  input  1  synchronous; terminates the current action
- light  output  1  light actuator drive
- sound  output  1  sound actuator drive
- motor  output  1  motor actuator drive
- busy  output  1  high in RUN and GAP
- done  output  1  one-cycle pulse at the end of every action, normal or aborted
- aborted  output  1  one-cycle pulse, coincident with done, when the action ended by abort
- exec_count  output  4  count of normally completed actions; wraps 15->0

## Operation
- FSM states: IDLE, RUN, GAP. Encoding is free. Counters, outputs and FSM state are all registered.
- IDLE
  - op_ready = !abort; light, sound, motor, busy, done and aborted are all 0.
  - Handshake when op_valid && op_ready at a rising edge. On that edge:
    - latch op_code into eff_q and dur_q;
    - load tick_cnt = (d+1)*TICK_CYCLES - 1;
    - go to RUN.
  - op_code is sampled only on the handshake edge. Changes to it at any other time have no effect.
- RUN
  - op_ready = 0, busy = 1.
  - Exactly one actuator output is high, selected by eff_q: 1 light, 2 sound, 3 motor. For eff 0 (nop) all actuators stay low, but the timing is identical.
  - tick_cnt decrements each cycle.
  - At tick_cnt == 0 with no abort: go to GAP and flag a normal completion.
  - abort = 1 in any RUN cycle: go to GAP on that edge and flag it as aborted. The remaining count is discarded.
- GAP (exactly 1 cycle)
  - All actuators are 0, op_ready = 0, busy = 1, done = 1.
  - aborted = 1 if the action was aborted.
  - exec_count increments on entry to GAP for a normal completion only.
  - Always goes to IDLE next cycle; abort during GAP has no further effect.
- Width rules
  - tick_cnt is wide enough to hold 4*TICK_CYCLES-1, i.e. clog2(4*TICK_CYCLES) bits (minimum 1).
  - Multiply and subtract are done at that width without truncation.
  - exec_count is modulo 16.
- abort asserted in IDLE: op_ready is forced low, so no handshake can occur that cycle. Abort wins over a simultaneous op_valid.
- Reset (any time, including mid-RUN)
  - State goes to IDLE; all outputs go to 0 except op_ready, which goes to 1.
  - exec_count, tick_cnt, eff_q and dur_q are cleared.
  - No done pulse is generated for an action cut off by reset.

## Timing
- Reset values: op_ready 1, light/sound/motor 0, busy 0, done 0, aborted 0, exec_count 0.
- Handshake at edge E:
  - actuator rises and busy rises after edge E (cycle E+1);
  - actuator stays high for exactly (d+1)*TICK_CYCLES cycles;
  - done is high in the following cycle;
  - op_ready returns the cycle after that.
- Per-opcode period, from handshake to the next possible handshake: (d+1)*TICK_CYCLES + 2 cycles.
- Abort sampled high at edge A in RUN: actuator falls and done/aborted pulse after A; op_ready is 1 one cycle later.
- No combinational path from op_valid to op_ready. op_ready depends only on state and abort.

## Test plan
- Reset, then hold op_valid=0: op_ready=1, all other outputs 0, exec_count=0 for 20 cycles.
- TICK_CYCLES=4, op_code=4'b0110 (light, d=2) for one handshake:
  - light high for exactly 12 cycles starting one cycle after the handshake, sound and motor low;
  - done=1 and aborted=0 for 1 cycle;
  - exec_count=1; op_ready=1 on the next cycle.
- Stream the 4 opcodes 4'b1010, 4'b1111, 4'b0000, 4'b0101 with op_valid held high:
  - sound for 12 cycles, motor for 16, then nop with no actuator for 4, then light for 8;
  - each action followed by 1 GAP cycle and 1 ready cycle;
  - exec_count=4.
- Motor opcode 4'b1111, abort pulsed in the 5th RUN cycle:
  - motor high 4 cycles then low;
  - done=1 and aborted=1 together;
  - exec_count unchanged.
- In IDLE, assert abort and op_valid together with op_code=4'b0100: op_ready=0 and no action starts; after abort drops, the opcode is accepted on the next edge.
- Run 17 normal nop actions (4'b0000, 4 cycles each): exec_count wraps 15->0->1. Then assert rst mid-RUN of a light action: light drops immediately, op_ready=1, exec_count=0, and no done pulse occurs.

Source files
------------

// File: rtl/effect_player.sv
// Opcode executor: accepts one opcode per handshake and drives a light, sound or
// motor actuator for (d+1)*TICK_CYCLES cycles, then a one-cycle done gap.
module effect_player #(
  parameter int TICK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [3:0] op_code,
  output logic       op_ready,
  input  logic       abort,
  output logic       light,
  output logic       sound,
  output logic       motor,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] exec_count
);

  localparam int CW = (4 * TICK_CYCLES > 1) ? $clog2(4 * TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICKS = CW'(TICK_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    eff_q, eff_d;
  logic [1:0]    dur_q, dur_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    exec_count_q, exec_count_d;
  logic          light_q, light_d;
  logic          sound_q, sound_d;
  logic          motor_q, motor_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [CW-1:0] tick_load;

  // Ready is the one output not registered: it must drop in the same cycle abort rises.
  assign op_ready   = (state_q == S_IDLE) && !abort;
  assign light      = light_q;
  assign sound      = sound_q;
  assign motor      = motor_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign exec_count = exec_count_q;

  // Modular arithmetic at CW bits still yields the right value when (d+1)*TICK_CYCLES == 2**CW.
  assign tick_load = ((CW'(op_code[1:0]) + ONE) * TICKS) - ONE;

  always_comb begin
    state_d      = state_q;
    eff_d        = eff_q;
    dur_d        = dur_q;
    tick_cnt_d   = tick_cnt_q;
    exec_count_d = exec_count_q;
    aborted_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          eff_d      = op_code[3:2];
          dur_d      = op_code[1:0];
          tick_cnt_d = tick_load;
          state_d    = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d    = S_GAP;
          tick_cnt_d = '0;
          aborted_d  = 1'b1;
        end else if (tick_cnt_q == '0) begin
          state_d      = S_GAP;
          exec_count_d = exec_count_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q - ONE;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered, one cycle after the edge.
    light_d = (state_d == S_RUN) && (eff_d == 2'd1);
    sound_d = (state_d == S_RUN) && (eff_d == 2'd2);
    motor_d = (state_d == S_RUN) && (eff_d == 2'd3);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      eff_q        <= 2'd0;
      dur_q        <= 2'd0;
      tick_cnt_q   <= '0;
      exec_count_q <= 4'd0;
      light_q      <= 1'b0;
      sound_q      <= 1'b0;
      motor_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      eff_q        <= eff_d;
      dur_q        <= dur_d;
      tick_cnt_q   <= tick_cnt_d;
      exec_count_q <= exec_count_d;
      light_q      <= light_d;
      sound_q      <= sound_d;
      motor_q      <= motor_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

endmodule

// File: tb/tb_effect_player.sv
// Self-checking bench for effect_player: table of opcodes with expected actuator
// lengths, a scoreboard queue of expected action results, and corner-case sequences.
module tb_effect_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [3:0] op_code = 4'd0;
  logic       abort = 1'b0;
  logic       op_ready, light, sound, motor, busy, done, aborted;
  logic [3:0] exec_count;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [3:0] op;
    int         light_n;
    int         sound_n;
    int         motor_n;
    int         done_at;
    logic       ab;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    int         ab_at;
    logic       hold;
    int         len;
    logic       ab;
  } vec_t;

  exp_t       sb[$];
  logic [3:0] exp_exec = 4'd0;

  effect_player #(.TICK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .abort(abort), .light(light), .sound(sound), .motor(motor), .busy(busy),
    .done(done), .aborted(aborted), .exec_count(exec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one action starting at a negedge in IDLE; checks are made at negedges.
  task automatic do_action(input logic [3:0] op, input int ab_at, input logic hold,
                           input int len, input logic ab);
    exp_t e, g;
    int   nl, ns, nm, dcyc, act;
    logic got_done, g_ab;
    logic [3:0] g_cnt;
    chk("ready_pre", op_ready, 1);
    op_code  = op;
    op_valid = 1'b1;
    e.op      = op;
    e.light_n = (op[3:2] == 2'd1) ? len : 0;
    e.sound_n = (op[3:2] == 2'd2) ? len : 0;
    e.motor_n = (op[3:2] == 2'd3) ? len : 0;
    e.done_at = len + 1;
    e.ab      = ab;
    if (!ab) exp_exec = exp_exec + 4'd1;
    e.cnt     = exp_exec;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    op_valid = hold;
    op_code  = 4'($urandom_range(0, 15));
    nl = 0; ns = 0; nm = 0; dcyc = 0; act = 0;
    got_done = 1'b0; g_ab = 1'b0; g_cnt = 4'd0;
    for (int c = 1; c <= 40 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
        dcyc  = c;
        g_ab  = aborted;
        g_cnt = exec_count;
        act   = int'(light) + int'(sound) + int'(motor);
      end else begin
        nl += int'(light);
        ns += int'(sound);
        nm += int'(motor);
        chk("busy_run", {busy, op_ready}, 2'b10);
        abort = (c == ab_at);
        @(negedge clk);
      end
    end
    abort = 1'b0;
    if (!got_done) begin
      chk("done_timeout", 0, 1);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      g = sb.pop_front();
      chk("light_len", nl, g.light_n);
      chk("sound_len", ns, g.sound_n);
      chk("motor_len", nm, g.motor_n);
      chk("done_at", dcyc, g.done_at);
      chk("aborted", g_ab, g.ab);
      chk("exec_count", g_cnt, g.cnt);
      chk("gap_act_off", act, 0);
      @(negedge clk);
      chk("ready_post", {op_ready, busy, done, aborted}, 4'b1000);
    end
  endtask

  vec_t vecs[6];
  int   rst_dones;

  initial begin
    vecs[0] = '{op: 4'b0110, ab_at: 0, hold: 1'b0, len: 12, ab: 1'b0};
    vecs[1] = '{op: 4'b1010, ab_at: 0, hold: 1'b1, len: 12, ab: 1'b0};
    vecs[2] = '{op: 4'b1111, ab_at: 0, hold: 1'b1, len: 16, ab: 1'b0};
    vecs[3] = '{op: 4'b0000, ab_at: 0, hold: 1'b1, len: 4,  ab: 1'b0};
    vecs[4] = '{op: 4'b0101, ab_at: 0, hold: 1'b0, len: 8,  ab: 1'b0};
    vecs[5] = '{op: 4'b1111, ab_at: 4, hold: 1'b0, len: 4,  ab: 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", {op_ready, light, sound, motor, busy, done, aborted, exec_count},
          11'b1_000000_0000);
    end

    for (int i = 0; i < 6; i++)
      do_action(vecs[i].op, vecs[i].ab_at, vecs[i].hold, vecs[i].len, vecs[i].ab);

    // Abort in IDLE wins over a simultaneous op_valid.
    abort = 1'b1; op_valid = 1'b1; op_code = 4'b0100;
    #1 chk("abort_idle_ready", op_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_idle_noact", {busy, light, op_ready}, 3'b000);
    abort = 1'b0;
    #1 chk("abort_drop_ready", op_ready, 1);
    do_action(4'b0100, 0, 1'b0, 4, 1'b0);

    // Fresh reset, then 17 nops to wrap exec_count through 15 -> 0 -> 1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_exec = 4'd0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) do_action(4'b0000, 0, 1'b0, 4, 1'b0);
    chk("wrap_count", exec_count, 4'd1);

    // Reset mid-RUN of a light action: immediate drop, no done pulse.
    op_code = 4'b0111; op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_run_light", light, 1);
    rst = 1'b1;
    #1 chk("rst_mid_run", {op_ready, light, sound, motor, busy, done, aborted, exec_count},
           11'b1_000000_0000);
    @(negedge clk);
    rst = 1'b0;
    rst_dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_dones += int'(done);
    end
    chk("rst_no_done", rst_dones, 0);
    chk("rst_idle_after", {op_ready, busy, exec_count}, 6'b10_0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
